// File: rtl/bufferm_rd_arbiter.sv
// Round-robin read arbiter for a PE's bufferM read port.
// Grants one requester per cycle and returns its data two cycles later with a one-hot valid.
module bufferm_rd_arbiter #(
    parameter int addrLen = 10,
    parameter int dataLen = 32,
    parameter int numReq  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [numReq-1:0]          req,
    input  logic [numReq*addrLen-1:0]  req_addr,
    output logic [numReq-1:0]          gnt,
    output logic [addrLen-1:0]         buf_rd_addr,
    input  logic [dataLen-1:0]         buf_data_in,
    output logic [numReq-1:0]          rsp_valid,
    output logic [dataLen-1:0]         rsp_data,
    output logic                       busy
);

    localparam int PW = (numReq > 1) ? $clog2(numReq) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    logic          s1_valid;
    logic [PW-1:0] s1_id;
    logic          s2_valid;
    logic [PW-1:0] s2_id;

    logic          rsp_live;

    // Scan requests starting at the pointer and wrapping; first hit wins.
    // Reset low or flush suppresses the grant entirely.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 0; off < numReq; off++) begin
            idx = (int'(ptr) + off) % numReq;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        if (!reset || flush) begin
            found = 1'b0;
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
    end

    // Two-stage pipeline matching bufferM's registered read; flush empties both stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            buf_rd_addr <= '0;
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            s2_valid    <= 1'b0;
            s2_id       <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s1_valid <= found;
            if (found) begin
                s1_id       <= win;
                buf_rd_addr <= req_addr[int'(win)*addrLen +: addrLen];
                if (int'(win) == numReq - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= win + PW'(1);
                end
            end
        end
    end

    // A response being flushed this cycle is hidden immediately, not just from next cycle on.
    always_comb begin
        rsp_live  = s2_valid && !flush;
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp_live) begin
            rsp_valid[s2_id] = 1'b1;
            rsp_data         = buf_data_in;
        end
    end

    assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_bufferm_rd_arbiter.sv
// Bench for bufferm_rd_arbiter: directed steps plus random traffic against a
// transaction-level model (grant list with issue cycles, memory array).
module tb_bufferm_rd_arbiter;

    localparam int AL = 10;
    localparam int DL = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [NR-1:0]     req;
    logic [NR*AL-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [AL-1:0]     buf_rd_addr;
    logic [DL-1:0]     buf_data_in;
    logic [NR-1:0]     rsp_valid;
    logic [DL-1:0]     rsp_data;
    logic              busy;

    bufferm_rd_arbiter #(.addrLen(AL), .dataLen(DL), .numReq(NR)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req), .req_addr(req_addr),
        .gnt(gnt), .buf_rd_addr(buf_rd_addr), .buf_data_in(buf_data_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // bufferM stand-in: registered read of a static array.
    logic [DL-1:0] mem [0:1023];
    always_ff @(posedge clk) buf_data_in <= mem[buf_rd_addr];

    typedef struct {
        int id;
        int addr;
        int cyc;
    } pend_t;
    pend_t q[$];

    int m_ptr, m_last_addr, m_win, cyc, n_cmp, n_err;
    bit m_has;
    logic [NR-1:0] obs_gnt, obs_rv;
    logic [DL-1:0] obs_rd;
    logic [AL-1:0] obs_addr;
    logic          obs_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NR*AL-1:0] addrs(input int a0, input int a1, input int a2, input int a3);
        logic [NR*AL-1:0] v;
        v = {AL'(a3), AL'(a2), AL'(a1), AL'(a0)};
        return v;
    endfunction

    task automatic checkOutput();
        logic [NR-1:0] exp_gnt, exp_rv;
        logic [DL-1:0] exp_rd;
        exp_gnt = '0;
        exp_rv  = '0;
        exp_rd  = '0;
        m_has   = 1'b0;
        m_win   = 0;
        if (reset && !flush) begin
            for (int off = 0; off < NR; off++) begin
                int k;
                k = (m_ptr + off) % NR;
                if (!m_has && req[k]) begin
                    m_has = 1'b1;
                    m_win = k;
                end
            end
        end
        if (m_has) exp_gnt[m_win] = 1'b1;
        if (reset && !flush && q.size() > 0 && q[0].cyc == cyc - 2) begin
            exp_rv[q[0].id] = 1'b1;
            exp_rd = mem[q[0].addr];
        end
        obs_gnt  = gnt;
        obs_rv   = rsp_valid;
        obs_rd   = rsp_data;
        obs_addr = buf_rd_addr;
        obs_busy = busy;
        check("gnt", 64'(gnt), 64'(exp_gnt));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_data", 64'(rsp_data), 64'(exp_rd));
        check("busy", 64'(busy), 64'(q.size() != 0));
        check("buf_rd_addr", 64'(buf_rd_addr), 64'(m_last_addr));
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*AL-1:0] a,
                                 input logic f, input logic rs);
        req      = r;
        req_addr = a;
        flush    = f;
        reset    = rs;
        if (!rs) begin
            q.delete();
            m_ptr       = 0;
            m_last_addr = 0;
        end
        #1;
        checkOutput();
        if (rs && !f) begin
            if (q.size() > 0 && q[0].cyc == cyc - 2) void'(q.pop_front());
            if (m_has) begin
                m_last_addr = int'(a[m_win*AL +: AL]);
                q.push_back('{m_win, m_last_addr, cyc});
                m_ptr = (m_win + 1) % NR;
            end
        end else if (rs && f) begin
            q.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    logic [NR-1:0] rq;
    logic [AL-1:0] ad [NR];

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        m_ptr = 0;
        m_last_addr = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'd1;
        mem[5] = 32'd0;
        reset = 1'b0;
        flush = 1'b0;
        req = '0;
        req_addr = '0;
        @(negedge clk);

        // Reset held low with random requests: everything quiet.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NR'($urandom), NR*AL'({$urandom, $urandom}), 1'b0, 1'b0);
            check("reset_gnt", 64'(obs_gnt), 64'(0));
            check("reset_busy", 64'(obs_busy), 64'(0));
        end
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("idle_rv", 64'(obs_rv), 64'(0));

        // Single reads from requester 1.
        applyStimulus(4'b0010, addrs(0, 0, 0, 0), 1'b0, 1'b1);
        check("single_gnt", 64'(obs_gnt), 64'(4'b0010));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("single_addr", 64'(obs_addr), 64'(0));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("single_rv", 64'(obs_rv), 64'(4'b0010));
        check("single_rd", 64'(obs_rd), 64'(1));
        applyStimulus(4'b0010, addrs(0, 5, 0, 0), 1'b0, 1'b1);
        check("single5_gnt", 64'(obs_gnt), 64'(4'b0010));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("single5_addr", 64'(obs_addr), 64'(5));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("single5_rv", 64'(obs_rv), 64'(4'b0010));
        check("single5_rd", 64'(obs_rd), 64'(0));

        // Wrap and skip: ptr is 2 here; grant 2 moves it to 3.
        applyStimulus(4'b0100, addrs(0, 0, 7, 0), 1'b0, 1'b1);
        applyStimulus(4'b0101, addrs(9, 0, 11, 0), 1'b0, 1'b1);
        check("wrap_gnt", 64'(obs_gnt), 64'(4'b0001));
        applyStimulus(4'b0100, addrs(0, 0, 11, 0), 1'b0, 1'b1);
        check("skip_gnt", 64'(obs_gnt), 64'(4'b0100));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1000, addrs(0, 0, 0, 20 + i), 1'b0, 1'b1);
            check("lone_gnt", 64'(obs_gnt), 64'(4'b1000));
        end
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);

        // Round-robin from reset.
        applyStimulus('0, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, addrs(100 + i, 200 + i, 300 + i, 400 + i), 1'b0, 1'b1);
            check("rr_gnt", 64'(obs_gnt), 64'(1 << (i % 4)));
        end
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);

        // Flush kills two in-flight reads; a request rising with flush waits one cycle.
        applyStimulus(4'b0001, addrs(30, 0, 0, 0), 1'b0, 1'b1);
        applyStimulus(4'b0001, addrs(31, 0, 0, 0), 1'b0, 1'b1);
        applyStimulus(4'b0010, addrs(0, 40, 0, 0), 1'b1, 1'b1);
        check("flush_gnt", 64'(obs_gnt), 64'(0));
        check("flush_rv", 64'(obs_rv), 64'(0));
        applyStimulus(4'b0010, addrs(0, 40, 0, 0), 1'b0, 1'b1);
        check("postflush_gnt", 64'(obs_gnt), 64'(4'b0010));
        check("postflush_rv", 64'(obs_rv), 64'(0));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("postflush_rv2", 64'(obs_rv), 64'(0));
        applyStimulus('0, '0, 1'b0, 1'b1);
        check("postflush_rsp", 64'(obs_rv), 64'(4'b0010));
        check("postflush_rd", 64'(obs_rd), 64'(mem[40]));

        // Reset mid-flight: the granted read never returns and ptr restarts at 0.
        applyStimulus(4'b0100, addrs(0, 0, 50, 0), 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b1);
            check("midreset_rv", 64'(obs_rv), 64'(0));
        end
        applyStimulus(4'b1111, addrs(1, 2, 3, 4), 1'b0, 1'b1);
        check("midreset_ptr", 64'(obs_gnt), 64'(4'b0001));

        // Random traffic obeying the hold-until-granted protocol.
        rq = 4'b1110;
        for (int i = 0; i < NR; i++) ad[i] = AL'($urandom);
        for (int n = 0; n < 400; n++) begin
            logic [NR*AL-1:0] av;
            logic f, rs;
            for (int i = 0; i < NR; i++) av[i*AL +: AL] = ad[i];
            f  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 49) != 0);
            applyStimulus(rq, av, f, rs);
            for (int i = 0; i < NR; i++) begin
                if (obs_gnt[i] || !rq[i]) begin
                    rq[i] = ($urandom_range(0, 2) != 0);
                    ad[i] = ($urandom_range(0, 7) == 0) ? AL'(5) : AL'($urandom);
                end
            end
        end
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
